// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared types for the pattern sequencer.
// Holds the pattern codes, the AUTO/MANUAL state type and the pattern-select width.
package pattern_seq_pkg;

  // Width of pattern_sel; covers up to eight patterns.
  localparam int unsigned PatSelWidth = 3;

  typedef logic [PatSelWidth-1:0] pat_sel_t;

  // Pattern codes as seen by the pattern generator.
  typedef enum logic [PatSelWidth-1:0] {
    PAT_BARS    = 3'd0,
    PAT_HRAMP   = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_GRID    = 3'd3,
    PAT_WHITE   = 3'd4,
    PAT_BLACK   = 3'd5
  } pattern_e;

  // Sequencer modes.
  typedef enum logic {
    SEQ_AUTO   = 1'b0,
    SEQ_MANUAL = 1'b1
  } seq_state_e;

  // Step to the next pattern index, wrapping from the last legal index to 0.
  function automatic pat_sel_t next_pattern(pat_sel_t cur, pat_sel_t last);
    return (cur == last) ? '0 : cur + pat_sel_t'(1);
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// pattern_sequencer_if: vsync/button inputs and pattern/LED outputs of the sequencer.
// master = the sequencer itself, slave = the display side that supplies vsync and buttons.
interface pattern_sequencer_if;
  import pattern_seq_pkg::*;

  logic     vsync;
  logic     btn_next;
  logic     btn_mode;
  pat_sel_t pattern_sel;
  logic     frame_start;
  logic     auto_mode;
  logic     frame_led;

  modport master (
    input  vsync,
    input  btn_next,
    input  btn_mode,
    output pattern_sel,
    output frame_start,
    output auto_mode,
    output frame_led
  );

  modport slave (
    output vsync,
    output btn_next,
    output btn_mode,
    input  pattern_sel,
    input  frame_start,
    input  auto_mode,
    input  frame_led
  );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: raw pushbutton -> one-cycle press pulse on the rising edge of the
// accepted level. Contains the 2-flop synchronizer and, when PATTERN_SEQ_DEBOUNCE_EN
// is defined, a stable-level counter; otherwise the synchronized level is used as-is.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 60000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic level;
  logic level_prev_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PATTERN_SEQ_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            level_q;

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q   <= '0;
      level_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign level = level_q;
`else
  assign level = sync2_q;
`endif

  // Previous accepted level for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level;
    end
  end

  // Release (falling edge) deliberately produces nothing.
  assign press_o = level & ~level_prev_q;

endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame-synchronous test-pattern selector plus 1 Hz heartbeat LED.
// Pattern changes are applied only at frame start so no frame mixes two patterns.
// Build macro: PATTERN_SEQ_DEBOUNCE_EN enables button debouncing (see btn_debounce).
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS     = 6,
  parameter int unsigned DWELL_FRAMES     = 180,
  parameter int unsigned LED_FRAMES       = 30,
  parameter int unsigned DEBOUNCE_CYCLES  = 60000,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  pattern_sequencer_if.master bus
);

  localparam int unsigned DwellW = $clog2(DWELL_FRAMES + 1);
  localparam int unsigned LedW   = $clog2(LED_FRAMES + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_FRAMES - 1);
  localparam logic [LedW-1:0]   LedLast   = LedW'(LED_FRAMES - 1);
  localparam pat_sel_t          PatLast   = pat_sel_t'(NUM_PATTERNS - 1);

  // Frame detect.
  logic vs_d_q;
  logic vs_prev_q;
  logic vs_act;
  logic frame_hit;

  // Button presses.
  logic next_press;
  logic mode_press;

  // Sequencer state and registered outputs.
  seq_state_e        state_q;
  pat_sel_t          pattern_q;
  logic [DwellW-1:0] dwell_q;
  logic [LedW-1:0]   led_cnt_q;
  logic              led_q;
  logic              pend_q;
  logic              frame_start_q;
  logic              advance;

  // Register vsync once; vs_d resets to the idle level so release never fakes a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_d_q    <= VSYNC_ACTIVE_LOW;
      vs_prev_q <= 1'b0;
    end else begin
      vs_d_q    <= bus.vsync;
      vs_prev_q <= vs_act;
    end
  end

  assign vs_act    = vs_d_q ^ VSYNC_ACTIVE_LOW;
  assign frame_hit = vs_act & ~vs_prev_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_next (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_next),
    .press_o (next_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.btn_mode),
    .press_o (mode_press)
  );

  // Decision uses the current (pre-toggle) state even if a mode press lands this cycle.
  assign advance = pend_q | ((state_q == SEQ_AUTO) & (dwell_q == DwellLast));

  // Sequencer FSM: frame-start advance, dwell/LED counters, pending press, mode toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEQ_AUTO;
      pattern_q     <= pat_sel_t'(PAT_BARS);
      dwell_q       <= '0;
      led_cnt_q     <= '0;
      led_q         <= 1'b0;
      pend_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_hit;

      if (frame_hit) begin
        if (advance) begin
          pattern_q <= next_pattern(pattern_q, PatLast);
          dwell_q   <= '0;
        end else if (state_q == SEQ_AUTO) begin
          dwell_q <= dwell_q + DwellW'(1);
        end

        if (led_cnt_q == LedLast) begin
          led_cnt_q <= '0;
          led_q     <= ~led_q;
        end else begin
          led_cnt_q <= led_cnt_q + LedW'(1);
        end
      end

      // A press on a frame-start cycle survives the clear and applies next frame.
      if (next_press) begin
        pend_q <= 1'b1;
      end else if (frame_hit && advance) begin
        pend_q <= 1'b0;
      end

      // Mode toggle is immediate; entering AUTO overrides any dwell update above.
      if (mode_press) begin
        unique case (state_q)
          SEQ_AUTO: begin
            state_q <= SEQ_MANUAL;
          end
          SEQ_MANUAL: begin
            state_q <= SEQ_AUTO;
            dwell_q <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pattern_sel = pattern_q;
  assign bus.frame_start = frame_start_q;
  assign bus.auto_mode   = (state_q == SEQ_AUTO);
  assign bus.frame_led   = led_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: frame-level reference model of the pattern sequencer driven
// by a synthetic vsync; button actions are placed mid-frame, well clear of frame starts.
module tb_pattern_sequencer;

  localparam int unsigned NumPatterns    = 6;
  localparam int unsigned DwellFrames    = 4;
  localparam int unsigned LedFrames      = 3;
  localparam int unsigned DebounceCycles = 8;
  localparam int unsigned FrameLen       = 64;
  localparam logic        VsAct          = 1'b0;
  localparam logic        VsIdle         = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  pattern_sequencer_if bus ();

  pattern_sequencer #(
    .NUM_PATTERNS     (NumPatterns),
    .DWELL_FRAMES     (DwellFrames),
    .LED_FRAMES       (LedFrames),
    .DEBOUNCE_CYCLES  (DebounceCycles),
    .VSYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state, kept at frame granularity.
  int m_sel;
  int m_dwell;
  int m_frames;
  bit m_auto;
  bit m_pend;
  bit m_led;

  task automatic model_reset();
    m_sel    = 0;
    m_dwell  = 0;
    m_frames = 0;
    m_auto   = 1'b1;
    m_pend   = 1'b0;
    m_led    = 1'b0;
  endtask

  task automatic model_frame_start();
    bit adv;
    adv = m_pend || (m_auto && (m_dwell == DwellFrames - 1));
    if (adv) begin
      m_sel   = (m_sel + 1) % NumPatterns;
      m_pend  = 1'b0;
      m_dwell = 0;
    end else if (m_auto) begin
      m_dwell = m_dwell + 1;
    end
    m_frames = m_frames + 1;
    m_led    = ((m_frames / LedFrames) % 2) == 1;
  endtask

  task automatic model_mid_frame(input int n_next, input bit mode, input bit bounce);
    if (mode) begin
      m_auto = !m_auto;
      if (m_auto) m_dwell = 0;
    end
    if (n_next > 0) m_pend = 1'b1;
`ifndef PATTERN_SEQ_DEBOUNCE_EN
    // Without debouncing every bounce edge is a press.
    if (bounce) m_pend = 1'b1;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b0;
    bus.vsync    = VsIdle;
    bus.btn_next = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // One full frame: vsync pulse with timing checks, then optional button activity.
  task automatic run_frame(input int n_next, input bit mode, input bit bounce);
    int old_sel;
    old_sel = m_sel;
    model_frame_start();
    @(negedge clk);
    bus.vsync = VsAct;
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_start !== 1'b0 || bus.pattern_sel !== 3'(old_sel)) begin
      failures++;
      $display("FAIL fs_early: frame_start=%0b pattern_sel=%0d, expected 0 and %0d",
               bus.frame_start, bus.pattern_sel, old_sel);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL fs_pulse: frame_start=%0b expected 1", bus.frame_start);
    end
    checks++;
    if (bus.pattern_sel !== 3'(m_sel)) begin
      failures++;
      $display("FAIL pattern_sel: got %0d expected %0d (frame %0d)",
               bus.pattern_sel, m_sel, m_frames);
    end
    checks++;
    if (bus.frame_led !== m_led) begin
      failures++;
      $display("FAIL frame_led: got %0b expected %0b (frame %0d)",
               bus.frame_led, m_led, m_frames);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL fs_width: frame_start=%0b expected 0", bus.frame_start);
    end
    for (int i = 3; i < int'(FrameLen); i++) begin
      @(negedge clk);
      if (i == 4) bus.vsync = VsIdle;
      if (i == 16) begin
        if (n_next > 0) bus.btn_next = 1'b1;
        if (mode) bus.btn_mode = 1'b1;
        model_mid_frame(n_next, mode, bounce);
      end
      if (bounce && i >= 16 && i < 46) bus.btn_next = (((i - 16) / 3) % 2) == 0;
      if (i == 28 || i == 46) begin
        bus.btn_next = 1'b0;
        bus.btn_mode = 1'b0;
      end
      if (i == 40 && n_next > 1) bus.btn_next = 1'b1;
      if (i == 52) bus.btn_next = 1'b0;
      if (i == 62) begin
        checks++;
        if (bus.auto_mode !== m_auto || bus.pattern_sel !== 3'(m_sel)) begin
          failures++;
          $display("FAIL mid_frame: auto_mode=%0b pattern_sel=%0d, expected %0b and %0d",
                   bus.auto_mode, bus.pattern_sel, m_auto, m_sel);
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.vsync    = VsIdle;
    bus.btn_next = 1'b0;
    bus.btn_mode = 1'b0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.pattern_sel !== 3'd0 || bus.frame_start !== 1'b0 ||
        bus.auto_mode !== 1'b1 || bus.frame_led !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: sel=%0d fs=%0b auto=%0b led=%0b, expected 0 0 1 0",
               bus.pattern_sel, bus.frame_start, bus.auto_mode, bus.frame_led);
    end
    reset = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (bus.frame_start !== 1'b0 || bus.pattern_sel !== 3'd0) begin
      failures++;
      $display("FAIL post_release: fs=%0b sel=%0d, expected 0 0",
               bus.frame_start, bus.pattern_sel);
    end
  endtask

  task automatic test_auto_cycle();
    for (int f = 0; f < 24; f++) run_frame(0, 1'b0, 1'b0);
    checks++;
    if (bus.pattern_sel !== 3'd0) begin
      failures++;
      $display("FAIL auto_wrap: pattern_sel=%0d expected 0", bus.pattern_sel);
    end
  endtask

  task automatic test_manual_hold();
    run_frame(0, 1'b1, 1'b0);
    checks++;
    if (bus.auto_mode !== 1'b0) begin
      failures++;
      $display("FAIL enter_manual: auto_mode=%0b expected 0", bus.auto_mode);
    end
    for (int f = 0; f < 10; f++) run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_manual_double_press();
    run_frame(1, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    checks++;
    if (bus.pattern_sel !== 3'd3) begin
      failures++;
      $display("FAIL double_press: pattern_sel=%0d expected 3", bus.pattern_sel);
    end
    run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_auto_pending();
    do_reset();
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    run_frame(1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
    checks++;
    if (bus.pattern_sel !== 3'd1) begin
      failures++;
      $display("FAIL pend_and_dwell: pattern_sel=%0d expected 1", bus.pattern_sel);
    end
    for (int f = 0; f < 4; f++) run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_bounce();
    run_frame(0, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    bit md;
    do_reset();
    for (int f = 0; f < 30; f++) begin
      n  = int'($urandom_range(0, 2));
      md = ($urandom_range(0, 3) == 0);
      run_frame(n, md, 1'b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int f = 0; f < 16; f++) run_frame(0, 1'b0, 1'b0);
    checks++;
    if (bus.pattern_sel !== 3'd4 || bus.frame_led !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_state: sel=%0d led=%0b, expected 4 1",
               bus.pattern_sel, bus.frame_led);
    end
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pattern_sel !== 3'd0 || bus.frame_start !== 1'b0 ||
        bus.auto_mode !== 1'b1 || bus.frame_led !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: sel=%0d fs=%0b auto=%0b led=%0b, expected 0 0 1 0",
               bus.pattern_sel, bus.frame_start, bus.auto_mode, bus.frame_led);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int f = 0; f < 6; f++) run_frame(0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_auto_cycle();
    test_manual_hold();
    test_manual_double_press();
    test_auto_pending();
    test_bounce();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
